// File: rtl/serial_word_rx_pkg.sv
// Shared types for the serial word receiver: assembly FSM encoding and bit-order constants.
// Imported by the receiver top level and its shift-in sub-module.
package serial_word_rx_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_shift_in.sv
// Serial-to-parallel shift register with bit counter; done pulses the cycle after the W-th bit.
// No backpressure: every shift_en bit is taken; clr abandons the partial count.
module serial_shift_in
    import serial_word_rx_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en,
    input  logic         clr,
    input  logic         bit_in,
    input  logic         order,
    output logic [W-1:0] shreg,
    output logic         last,
    output logic         done
);

    localparam int CW = $clog2(W) + 1;

    logic [CW-1:0] cnt;

    assign last = shift_en && !clr && (cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (clr) begin
                cnt <= '0;
            end else if (shift_en) begin
                if (order == MSB_FIRST)
                    shreg <= {shreg[W-2:0], bit_in};
                else
                    shreg <= {bit_in, shreg[W-1:1]};
                cnt <= last ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_word_rx.sv
// Deserializer: W serial bits -> one parallel word; word_valid rises one edge after the W-th bit.
// Valid/ready output; a word completing while the previous one is unconsumed is dropped and flags overrun.
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_valid,
    input  logic         bit_in,
    input  logic         lr_select,
    input  logic         sync_clr,
    input  logic         word_ready,
    output logic [W-1:0] word_out,
    output logic         word_valid,
    output logic         overrun
);

    state_t       state_q, state_d;
    logic         order_q;
    logic         order_eff;
    logic         shift_en;
    logic         last;
    logic         done;
    logic [W-1:0] shreg;

    assign shift_en = bit_valid && !sync_clr;
    // The first bit of a word uses the live select; later bits use the latched one.
    assign order_eff = (state_q == IDLE) ? lr_select : order_q;

    serial_shift_in #(.W(W)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .clr      (sync_clr),
        .bit_in   (bit_in),
        .order    (order_eff),
        .shreg    (shreg),
        .last     (last),
        .done     (done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (shift_en) state_d = COLLECT;
            COLLECT: if (sync_clr || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            order_q <= MSB_FIRST;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && shift_en)
                order_q <= lr_select;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!word_valid || word_ready) begin
                word_out   <= shreg;
                word_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench for serial_word_rx: directed scenarios plus random traffic against a bit-list model.
module tb_serial_word_rx;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         bit_valid = 1'b0;
    logic         bit_in = 1'b0;
    logic         lr_select = 1'b0;
    logic         sync_clr = 1'b0;
    logic         word_ready = 1'b0;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         overrun;

    always #5 clk = ~clk;

    serial_word_rx #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .lr_select  (lr_select),
        .sync_clr   (sync_clr),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overrun    (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cycles = 0;
    logic [W-1:0] last_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of received bits; a word is the list placed by position.
    bit           m_bits[$];
    bit           m_order = 1'b0;
    bit           m_pend = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_ovr = 1'b0;
    bit [W-1:0]   m_pend_word = '0;
    bit [W-1:0]   m_word = '0;
    logic [W-1:0] exp_q[$];

    function automatic bit [W-1:0] assemble(input bit bits[$], input bit order);
        bit [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (order) w[i] = bits[i];
            else       w[W-1-i] = bits[i];
        end
        return w;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_bits.delete();
            m_order = 1'b0;
            m_pend  = 1'b0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_word  = '0;
            exp_q.delete();
        end else begin
            if (m_pend) begin
                if (!m_valid || word_ready) begin
                    m_valid = 1'b1;
                    m_word  = m_pend_word;
                    exp_q.push_back(m_pend_word);
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && word_ready) begin
                m_valid = 1'b0;
            end
            m_pend = 1'b0;
            if (sync_clr) begin
                m_bits.delete();
            end else if (bit_valid) begin
                if (m_bits.size() == 0) m_order = lr_select;
                m_bits.push_back(bit_in);
                if (m_bits.size() == W) begin
                    m_pend_word = assemble(m_bits, m_order);
                    m_pend = 1'b1;
                    m_bits.delete();
                end
            end
        end
    end

    // Monitor: samples mid-cycle, pops the scoreboard on every handshake.
    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        check("word_valid", 32'(word_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (word_valid) begin
            valid_cycles++;
            check("word_out_held", 32'(word_out), 32'(m_word));
        end
        if (word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got word %0h expected none at %0t", word_out, $time);
            end else begin
                exp_w = exp_q.pop_front();
                check("scoreboard_word", 32'(word_out), 32'(exp_w));
            end
            last_word = word_out;
        end
    end

    task automatic cyc(input bit bv, input bit bi, input bit lr, input bit sc, input bit rdy);
        @(posedge clk);
        #1;
        bit_valid  = bv;
        bit_in     = bi;
        lr_select  = lr;
        sync_clr   = sc;
        word_ready = rdy;
    endtask

    // tx[W-1] is transmitted first.
    task automatic send_word(input logic [W-1:0] tx, input bit lr, input bit rdy);
        for (int i = W - 1; i >= 0; i--) cyc(1'b1, tx[i], lr, 1'b0, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_word_out", 32'(word_out), 32'd0);
        check("reset_word_valid", 32'(word_valid), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;

        // MSB-first single word, always ready
        valid_cycles = 0;
        send_word(5'b10110, 1'b0, 1'b1);
        idle(4, 1'b1);
        check("msb_word", 32'(last_word), 32'h16);
        check("msb_valid_cycles", 32'(valid_cycles), 32'd1);

        // LSB-first, same bit stream
        send_word(5'b10110, 1'b1, 1'b1);
        idle(4, 1'b1);
        check("lsb_word", 32'(last_word), 32'h0D);

        // Two back-to-back words without ready: second is dropped
        send_word(5'b11001, 1'b0, 1'b0);
        send_word(5'b00111, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        check("first_word_held", 32'(word_out), 32'h19);
        idle(1, 1'b1);
        idle(3, 1'b0);
        check("first_word_consumed", 32'(last_word), 32'h19);
        check("second_not_presented", 32'(word_valid), 32'd0);

        // Completion coincides with consume
        send_word(5'b01010, 1'b0, 1'b0);
        idle(2, 1'b0);
        send_word(5'b10011, 1'b0, 1'b0);
        idle(1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("coincide_valid", 32'(word_valid), 32'd1);
        check("coincide_word", 32'(word_out), 32'h13);
        idle(3, 1'b1);

        // Abort of a partial word
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        send_word(5'b11111, 1'b0, 1'b1);
        idle(4, 1'b1);
        check("sync_clr_word", 32'(last_word), 32'h1F);

        // Asynchronous reset mid-word, between clock edges
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_word_out", 32'(word_out), 32'd0);
        check("async_rst_word_valid", 32'(word_valid), 32'd0);
        check("async_rst_overrun", 32'(overrun), 32'd0);
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_word(5'b00001, 1'b0, 1'b1);
        idle(4, 1'b1);
        check("post_reset_word", 32'(last_word), 32'h01);
        check("post_reset_overrun", 32'(overrun), 32'd0);

        // Random traffic: gaps, order changes mid-word, aborts, backpressure
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end
        idle(8, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
